// File: rtl/sha3_pkg.sv
// sha3_pkg: types and helpers shared by the SHA3 datapath blocks and their benches.
//   lane_t    - one Keccak lane (LANE_W bits)
//   state_t   - full 5x5 Keccak state, indexed [x][y]
//   lane_x/y  - map a linear lane number k to its (x, y) position
//   byte_rev  - reverse the low nbytes bytes of a lane (hash byte order)
//   tx_state_e- digest transmitter FSM states
package sha3_pkg;

    localparam int LANE_W = 64;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [0:4][0:4]  state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    function automatic int lane_x(input int k);
        return k % 5;
    endfunction

    function automatic int lane_y(input int k);
        return k / 5;
    endfunction

    // Byte 0 (bits [7:0]) of the input lands in the most significant of the
    // nbytes result bytes, so reading the result MSB-first gives hash order.
    function automatic lane_t byte_rev(input lane_t x, input int nbytes);
        lane_t r;
        r = '0;
        for (int b = 0; b < LANE_W / 8; b++) begin
            if (b < nbytes) begin
                r[8*(nbytes-1-b) +: 8] = x[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sha3_lane_select.sv
// sha3_lane_select: picks digest byte cnt_i out of the hash-ordered digest register.
//   digest_i - NBYTES bytes, hash byte 0 in the most significant byte
//   cnt_i    - index of the byte currently being sent
//   byte_o   - selected byte
module sha3_lane_select #(
    parameter int NBYTES = 32,
    parameter int CW     = 5
) (
    input  logic [NBYTES*8-1:0] digest_i,
    input  logic [CW-1:0]       cnt_i,
    output logic [7:0]          byte_o
);

    always_comb begin
        byte_o = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (cnt_i == CW'(i)) begin
                byte_o = digest_i[(NBYTES-1-i)*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/sha3_digest_tx.sv
// sha3_digest_tx: captures the first DIGEST_LANES lanes of a finished Keccak
// state in hash byte order and streams them out one byte per handshake.
//   clk, nrst     - clock, asynchronous active-low reset
//   State_in      - Keccak state, lane k at State_in[k%5][k/5]
//   State_valid   - state is final (sampled every cycle)
//   Byte_out      - current digest byte, Byte_valid qualifies it
//   Byte_ready    - sink accepts Byte_out
//   Last_byte     - Byte_out is the final digest byte
//   Busy          - a digest is held or being sent
//   Overrun       - State_valid seen while busy and dropped (same-cycle pulse)
// Handshake: a byte moves on a rising edge where Byte_valid && Byte_ready.
// Once Byte_valid is high it stays high, with Byte_out/Last_byte stable,
// until that byte moves; the sink may hold Byte_ready low indefinitely.
// WIDTH must be a multiple of 8 and no larger than sha3_pkg::LANE_W.
module sha3_digest_tx
    import sha3_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int DIGEST_LANES = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [0:4][0:4][WIDTH-1:0]   State_in,
    input  logic                         State_valid,
    output logic [7:0]                   Byte_out,
    output logic                         Byte_valid,
    input  logic                         Byte_ready,
    output logic                         Last_byte,
    output logic                         Busy,
    output logic                         Overrun
);

    localparam int NBYTES = DIGEST_LANES * WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int DW     = NBYTES * 8;

    tx_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  digest_q, digest_d;

    logic [DW-1:0]  capt_digest;
    lane_t          rev_lane;
    logic           capture;
    logic           xfer;
    logic           last;
    logic [7:0]     sel_byte;

    // Lanes beyond DIGEST_LANES are never sent; fold them away here.
    logic           unused_state;
    assign unused_state = ^State_in;

    // Hash-ordered image of the incoming state: lane 0 reversed occupies the
    // top WIDTH bits so hash byte 0 is the most significant byte.
    always_comb begin
        capt_digest = '0;
        rev_lane    = '0;
        for (int k = 0; k < DIGEST_LANES; k++) begin
            rev_lane = byte_rev(lane_t'(State_in[lane_x(k)][lane_y(k)]), WIDTH / 8);
            capt_digest[(DIGEST_LANES-1-k)*WIDTH +: WIDTH] = rev_lane[WIDTH-1:0];
        end
    end

    assign xfer = (state_q == ST_SEND) && Byte_ready;
    assign last = (state_q == ST_SEND) && (cnt_q == CW'(NBYTES - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digest_d = digest_q;
        capture  = 1'b0;
        Overrun  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (State_valid) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer && last) begin
                    cnt_d = '0;
                    // A new state arriving with the final transfer is taken
                    // immediately so consecutive digests have no gap.
                    if (State_valid) begin
                        capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (xfer) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    Overrun = State_valid;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (capture) begin
            digest_d = capt_digest;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digest_q <= digest_d;
        end
    end

    sha3_lane_select #(
        .NBYTES (NBYTES),
        .CW     (CW)
    ) u_sel (
        .digest_i (digest_q),
        .cnt_i    (cnt_q),
        .byte_o   (sel_byte)
    );

    assign Byte_valid = (state_q == ST_SEND);
    assign Busy       = (state_q == ST_SEND);
    assign Last_byte  = last;
    assign Byte_out   = (state_q == ST_SEND) ? sel_byte : 8'h00;

endmodule

// File: tb/tb_sha3_digest_tx.sv
module tb_sha3_digest_tx;
  import sha3_pkg::*;

  logic clk;
  logic nrst;
  logic [0:4][0:4][63:0] st;
  logic sv;
  logic rdy;

  logic [7:0] b4, b8, b1;
  logic v4, v8, v1, l4, l8, l1, bz4, bz8, bz1, o4, o8, o1;

  int n_vec;
  int n_err;

  // SHA3-256("") in hash order.
  logic [255:0] hash_a;

  sha3_digest_tx #(.WIDTH(64), .DIGEST_LANES(4)) dut (
    .clk(clk), .nrst(nrst), .State_in(st), .State_valid(sv),
    .Byte_out(b4), .Byte_valid(v4), .Byte_ready(rdy), .Last_byte(l4),
    .Busy(bz4), .Overrun(o4)
  );

  sha3_digest_tx #(.WIDTH(64), .DIGEST_LANES(8)) dut8 (
    .clk(clk), .nrst(nrst), .State_in(st), .State_valid(sv),
    .Byte_out(b8), .Byte_valid(v8), .Byte_ready(rdy), .Last_byte(l8),
    .Busy(bz8), .Overrun(o8)
  );

  sha3_digest_tx #(.WIDTH(64), .DIGEST_LANES(1)) dut1 (
    .clk(clk), .nrst(nrst), .State_in(st), .State_valid(sv),
    .Byte_out(b1), .Byte_valid(v1), .Byte_ready(rdy), .Last_byte(l1),
    .Busy(bz1), .Overrun(o1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic fill_state();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        st[x][y] = 64'heeeeeeeeeeeeeeee;
  endtask

  task automatic load_a();
    fill_state();
    st[0][0] = 64'h66d71ebff8c6ffa7;
    st[1][0] = 64'h62d661a05647c151;
    st[2][0] = 64'hfa493be44dff80f5;
    st[3][0] = 64'h4a43f8804b0ad882;
  endtask

  // Pattern B: byte b of lane k is 0x80 + 8k + b, so hash byte i is 0x80 + i.
  task automatic load_b();
    logic [63:0] lane;
    fill_state();
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < 8; b++) lane[8*b +: 8] = 8'(8'h80 + 8*k + b);
      st[k % 5][k / 5] = lane;
    end
  endtask

  function automatic logic [7:0] a_byte(input int i);
    return hash_a[255 - 8*i -: 8];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if ({v4, bz4, l4, o4, b4} !== 12'h000) begin n_err++; $display("FAIL reset_dut: got %h expected 000", {v4, bz4, l4, o4, b4}); end
    n_vec++; if ({v8, bz8, l8, o8, b8} !== 12'h000) begin n_err++; $display("FAIL reset_dut8: got %h expected 000", {v8, bz8, l8, o8, b8}); end
    n_vec++; if ({v1, bz1, l1, o1, b1} !== 12'h000) begin n_err++; $display("FAIL reset_dut1: got %h expected 000", {v1, bz1, l1, o1, b1}); end
    n_vec++; if (byte_rev(64'h66d71ebff8c6ffa7, 8) !== 64'ha7ffc6f8bf1ed766) begin n_err++; $display("FAIL byte_rev: got %h expected a7ffc6f8bf1ed766", byte_rev(64'h66d71ebff8c6ffa7, 8)); end
    nrst = 1'b1;
    @(negedge clk);
    n_vec++; if (bz4 !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: busy got %b expected 0", bz4); end
  endtask

  task automatic test_empty_msg();
    load_a(); rdy = 1'b1; sv = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      sv = 1'b0; #1;
      n_vec++; if (v4 !== 1'b1) begin n_err++; $display("FAIL empty_valid[%0d]: got %b expected 1", i, v4); end
      n_vec++; if (b4 !== a_byte(i)) begin n_err++; $display("FAIL empty_byte[%0d]: got %h expected %h", i, b4, a_byte(i)); end
      n_vec++; if (l4 !== (i == 31)) begin n_err++; $display("FAIL empty_last[%0d]: got %b expected %b", i, l4, (i == 31)); end
      @(negedge clk);
    end
    n_vec++; if (bz4 !== 1'b0) begin n_err++; $display("FAIL empty_done_busy: got %b expected 0", bz4); end
  endtask

  task automatic test_backpressure();
    int i, cyc;
    logic r, stalled;
    logic [7:0] pb;
    logic pl;
    load_a(); rdy = 1'b1; sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    i = 0; cyc = 0; stalled = 1'b0; pb = 8'h00; pl = 1'b0;
    while (i < 32 && cyc < 400) begin
      n_vec++; if (v4 !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, v4); end
      n_vec++; if (b4 !== a_byte(i)) begin n_err++; $display("FAIL bp_byte[%0d]: got %h expected %h", i, b4, a_byte(i)); end
      n_vec++; if (l4 !== (i == 31)) begin n_err++; $display("FAIL bp_last[%0d]: got %b expected %b", i, l4, (i == 31)); end
      if (stalled) begin
        n_vec++; if ({b4, l4} !== {pb, pl}) begin n_err++; $display("FAIL bp_stable[%0d]: got %h expected %h", i, {b4, l4}, {pb, pl}); end
      end
      case (cyc)
        0: r = 1'b1;
        1, 2: r = 1'b0;
        3: r = 1'b1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      rdy = r; pb = b4; pl = l4; stalled = !r;
      if (r) i++;
      @(negedge clk);
      cyc++;
    end
    rdy = 1'b1;
    n_vec++; if (i != 32) begin n_err++; $display("FAIL bp_timeout: got %0d bytes expected 32", i); end
    n_vec++; if (bz4 !== 1'b0) begin n_err++; $display("FAIL bp_done_busy: got %b expected 0", bz4); end
  endtask

  task automatic test_overrun();
    load_a(); rdy = 1'b1; sv = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      sv = (i == 10);
      if (i == 10) load_b();
      #1;
      n_vec++; if (o4 !== (i == 10)) begin n_err++; $display("FAIL ovr_pulse[%0d]: got %b expected %b", i, o4, (i == 10)); end
      n_vec++; if (b4 !== a_byte(i)) begin n_err++; $display("FAIL ovr_byte[%0d]: got %h expected %h", i, b4, a_byte(i)); end
      n_vec++; if (l4 !== (i == 31)) begin n_err++; $display("FAIL ovr_last[%0d]: got %b expected %b", i, l4, (i == 31)); end
      @(negedge clk);
    end
    sv = 1'b0;
    n_vec++; if (bz4 !== 1'b0) begin n_err++; $display("FAIL ovr_done_busy: got %b expected 0", bz4); end
  endtask

  task automatic test_back_to_back();
    load_a(); rdy = 1'b1; sv = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      sv = (i == 31);
      if (i == 31) load_b();
      #1;
      n_vec++; if (b4 !== a_byte(i)) begin n_err++; $display("FAIL b2b_first[%0d]: got %h expected %h", i, b4, a_byte(i)); end
      n_vec++; if (o4 !== 1'b0) begin n_err++; $display("FAIL b2b_overrun[%0d]: got %b expected 0", i, o4); end
      @(negedge clk);
    end
    for (int j = 0; j < 32; j++) begin
      sv = 1'b0; #1;
      n_vec++; if (v4 !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", j, v4); end
      n_vec++; if (b4 !== 8'(8'h80 + j)) begin n_err++; $display("FAIL b2b_second[%0d]: got %h expected %h", j, b4, 8'(8'h80 + j)); end
      n_vec++; if (l4 !== (j == 31)) begin n_err++; $display("FAIL b2b_last[%0d]: got %b expected %b", j, l4, (j == 31)); end
      @(negedge clk);
    end
    n_vec++; if (bz4 !== 1'b0) begin n_err++; $display("FAIL b2b_done_busy: got %b expected 0", bz4); end
  endtask

  task automatic test_reset_midstream();
    load_a(); rdy = 1'b1; sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    n_vec++; if (b4 !== a_byte(5)) begin n_err++; $display("FAIL rst_pre_byte: got %h expected %h", b4, a_byte(5)); end
    #2 nrst = 1'b0;
    #1;
    n_vec++; if ({v4, bz4, l4, o4, b4} !== 12'h000) begin n_err++; $display("FAIL rst_async: got %h expected 000", {v4, bz4, l4, o4, b4}); end
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (bz4 !== 1'b0) begin n_err++; $display("FAIL rst_idle[%0d]: busy got %b expected 0", i, bz4); end
    end
    sv = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      sv = 1'b0; #1;
      n_vec++; if (b4 !== a_byte(i)) begin n_err++; $display("FAIL rst_fresh[%0d]: got %h expected %h", i, b4, a_byte(i)); end
      @(negedge clk);
    end
    n_vec++; if (bz4 !== 1'b0) begin n_err++; $display("FAIL rst_done_busy: got %b expected 0", bz4); end
  endtask

  task automatic test_param_sweep();
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    load_b(); rdy = 1'b1; sv = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      sv = 1'b0; #1;
      n_vec++; if (b8 !== 8'(8'h80 + i)) begin n_err++; $display("FAIL sw8_byte[%0d]: got %h expected %h", i, b8, 8'(8'h80 + i)); end
      n_vec++; if (l8 !== (i == 63)) begin n_err++; $display("FAIL sw8_last[%0d]: got %b expected %b", i, l8, (i == 63)); end
      if (i < 32) begin
        n_vec++; if (b4 !== 8'(8'h80 + i)) begin n_err++; $display("FAIL sw4_byte[%0d]: got %h expected %h", i, b4, 8'(8'h80 + i)); end
      end
      if (i == 32) begin
        n_vec++; if (bz4 !== 1'b0) begin n_err++; $display("FAIL sw4_done_busy: got %b expected 0", bz4); end
      end
      if (i < 8) begin
        n_vec++; if (b1 !== 8'(8'h80 + i)) begin n_err++; $display("FAIL sw1_byte[%0d]: got %h expected %h", i, b1, 8'(8'h80 + i)); end
        n_vec++; if (l1 !== (i == 7)) begin n_err++; $display("FAIL sw1_last[%0d]: got %b expected %b", i, l1, (i == 7)); end
      end
      if (i == 8) begin
        n_vec++; if (bz1 !== 1'b0) begin n_err++; $display("FAIL sw1_done_busy: got %b expected 0", bz1); end
      end
      @(negedge clk);
    end
    n_vec++; if (bz8 !== 1'b0) begin n_err++; $display("FAIL sw8_done_busy: got %b expected 0", bz8); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    hash_a = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
    nrst = 1'b0;
    sv = 1'b0;
    rdy = 1'b1;
    fill_state();
    test_reset();
    test_empty_msg();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_midstream();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
